instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/mem/writeback sequencer.
// All outputs are registered from the next-state decode, so each strobe lines up with its state.
module instr_sequencer #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instrword,
    output logic        newinstr,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    localparam logic [5:0] OP_R  = 6'd0;
    localparam logic [5:0] OP_LW = 6'd35;
    localparam logic [5:0] OP_SW = 6'd43;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [15:0] r_count;
    logic        r_req, r_new, r_rw, r_mr, r_mw, r_busy, r_halt, r_ill;
    logic        w_req_n, w_new_n, w_rw_n, w_mr_n, w_mw_n, w_busy_n, w_halt_n, w_ill_n;
    logic [5:0]  w_op;
    logic        w_legal;
    logic        w_retire;

    assign w_op     = r_instr[31:26];
    assign w_legal  = (r_instr != HALT_WORD) && (w_op == OP_R || w_op == OP_LW || w_op == OP_SW);
    // MEM is only reached by LW/SW, so a non-LW MEM cycle is a store retiring
    assign w_retire = (r_state == WB) || (r_state == MEM && w_op != OP_LW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= PC_RESET;
            r_instr <= '0;
            r_count <= '0;
            r_req   <= 1'b0;
            r_new   <= 1'b0;
            r_rw    <= 1'b0;
            r_mr    <= 1'b0;
            r_mw    <= 1'b0;
            r_busy  <= 1'b0;
            r_halt  <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= w_req_n;
            r_new   <= w_new_n;
            r_rw    <= w_rw_n;
            r_mr    <= w_mr_n;
            r_mw    <= w_mw_n;
            r_busy  <= w_busy_n;
            r_halt  <= w_halt_n;
            r_ill   <= w_ill_n;
            if (r_state == FETCH && imem_ack)
                r_instr <= imem_data;
            if (w_retire) begin
                r_pc    <= r_pc + 32'd4;
                r_count <= r_count + {15'd0, r_count != 16'hFFFF};
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? FETCH : IDLE;
            FETCH:   w_next = imem_ack ? DECODE : FETCH;
            DECODE:  w_next = w_legal ? EXEC : HALT;
            EXEC:    w_next = (w_op == OP_R) ? WB : MEM;
            MEM:     w_next = (w_op == OP_LW) ? WB : FETCH;
            WB:      w_next = FETCH;
            default: w_next = HALT;
        endcase
    end

    always_comb begin
        w_req_n  = w_next == FETCH;
        w_new_n  = w_next == DECODE;
        w_rw_n   = w_next == WB;
        w_mr_n   = w_next == MEM && w_op == OP_LW;
        w_mw_n   = w_next == MEM && w_op == OP_SW;
        w_busy_n = w_next != IDLE && w_next != HALT;
        w_halt_n = w_next == HALT;
        w_ill_n  = (r_state == HALT) ? r_ill : (w_next == HALT && r_instr != HALT_WORD);
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instrword   = r_instr;
    assign newinstr    = r_new;
    assign regwrite    = r_rw;
    assign memread     = r_mr;
    assign memwrite    = r_mw;
    assign busy        = r_busy;
    assign halted      = r_halt;
    assign illegal     = r_ill;
    assign instr_count = r_count;
endmodule
